instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning prefetch buffer entries; only powers of two from 2 to 8 are legal.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req, output, 1 bit: an instruction memory read is requested.
REQ-006 SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-007 SHALL have port imem_ack, input, 1 bit: read complete; imem_rdata is valid this cycle.
REQ-008 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 SHALL have port instr_valid, output, 1 bit: instruction, pc and pcNext are valid.
REQ-010 SHALL have port instr_ready, input, 1 bit: the core consumes the head instruction this cycle.
REQ-011 SHALL have port instruction, output, 32 bits: head instruction, driving the core instruction input.
REQ-012 SHALL have port pc, output, 32 bits: address of the head instruction.
REQ-013 SHALL have port pcNext, output, 32 bits: pc+4, driving the core pcNext input.
REQ-014 SHALL have port redirect, input, 1 bit: control-flow change (JAL/branch taken).
REQ-015 SHALL have port redirect_pc, input, 32 bits: new fetch target.

Function
REQ-016 SHALL implement FSM states FETCH (no request outstanding), WAIT_ACK (request outstanding) and DISCARD (outstanding request is stale).
REQ-017 SHALL, in FETCH, assert imem_req with imem_addr=fetch_pc when occupancy < DEPTH, then enter WAIT_ACK.
REQ-018 SHALL hold imem_req high and imem_addr stable in WAIT_ACK until imem_ack; at most one request SHALL be outstanding.
REQ-019 SHALL, on imem_ack in WAIT_ACK, push {imem_rdata, imem_addr} into the buffer, set fetch_pc to fetch_pc+4 modulo 2^32, and return to FETCH; 32'hFFFF_FFFC SHALL wrap to 0.
REQ-020 SHALL reserve a buffer slot when a request is issued, so a push never overflows.
REQ-021 SHALL assert instr_valid iff the buffer is non-empty; instruction and pc SHALL be the head entry and pcNext SHALL equal pc+4 (wrapping).
REQ-022 SHALL pop the head when instr_valid and instr_ready are both high; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 SHALL, on redirect, flush the buffer, deassert instr_valid from the next cycle, and set fetch_pc to {redirect_pc[31:2], 2'b00}.
REQ-024 SHALL, on redirect in WAIT_ACK without imem_ack, enter DISCARD, hold the stale request until imem_ack, drop that data, then request the redirect target.
REQ-025 SHALL, on redirect coincident with imem_ack, drop the ack data and enter FETCH.
REQ-026 SHALL, on redirect in DISCARD, update fetch_pc and remain in DISCARD.
REQ-027 SHALL give redirect priority over instr_ready in the same cycle.
REQ-028 SHALL have a latency of one cycle from imem_ack to instr_valid when the bypass described in REQ-033 is absent.

Reset
REQ-029 SHALL, while rst is high, force state=FETCH, fetch_pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC and instr_valid=0.
REQ-030 SHALL, when rst is asserted mid-request, drop imem_req asynchronously and ignore any imem_ack arriving during reset.
REQ-031 SHALL assert imem_req for RESET_PC in the first cycle after rst deasserts.
REQ-032 SHALL reset instruction, pc and pcNext to 0, RESET_PC and RESET_PC+4 respectively.

Configuration
REQ-033 SHALL, with FETCH_BYPASS_EN defined and the buffer empty, present imem_rdata and imem_addr on instruction and pc combinationally in the ack cycle with instr_valid=1; if instr_ready is also high the word SHALL not be pushed, and bypass SHALL be suppressed in a redirect cycle or in DISCARD.
REQ-034 SHALL, without FETCH_BYPASS_EN, always route ack data through the buffer, giving the 1-cycle latency of REQ-028.

Verification
REQ-035 SHALL cover: release rst with RESET_PC=0x100 and a memory acking after 1 cycle -> imem_addr sequence 0x100, 0x104, 0x108; instr_valid one cycle after the first ack; pcNext=0x104.
REQ-036 SHALL cover: instr_ready held 0 with DEPTH=2 -> exactly 2 requests issued, then imem_req stays 0; one pop -> exactly one new request.
REQ-037 SHALL cover: redirect to 0x2002 while a request to 0x10C is outstanding with a 3-cycle ack -> 0x10C data never appears on instruction; next imem_addr=0x2000.
REQ-038 SHALL cover: redirect coincident with imem_ack -> ack data dropped; imem_addr=redirect target the next cycle; no DISCARD entry.
REQ-039 SHALL cover: fetch_pc=0xFFFF_FFFC -> pcNext=0 and the next imem_addr=0.
REQ-040 SHALL cover: FETCH_BYPASS_EN defined, empty buffer, instr_ready=1 -> instr_valid in the ack cycle; buffer occupancy stays 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Instruction fetch unit. Issues one word-aligned read at a time
//               to instruction memory. Returned words go into a small prefetch
//               buffer. The head of that buffer is presented to the core.
//               A redirect flushes the buffer. If a read is still outstanding
//               when the redirect arrives, the unit waits for that read to
//               complete and drops its data.
//               Optional feature macro: FETCH_BYPASS_EN. When it is defined
//               and the buffer is empty, the unit forwards the ack data
//               straight to the core in the ack cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pcNext,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_1 = PTR_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_1 = CNT_W'(1);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_ACK = 2'd1,
    DISCARD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_addr;
  logic [31:0]      r_instr_mem [DEPTH];
  logic [31:0]      r_pc_mem    [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_room;
  logic w_buf_valid;
  logic w_ack_live;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_unused_ok;

  // The low two bits of a redirect target are ignored because fetches are word-aligned.
  assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

  // Only one read is outstanding at a time. A request is issued only from
  // FETCH, and only when count < DEPTH. That reserves the slot before the
  // push, so a push can never overflow the buffer.
  assign w_room      = (r_count < C_DEPTH);
  assign w_buf_valid = (r_count != '0);
  assign w_ack_live  = (r_state == WAIT_ACK) && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_ack_live && !w_buf_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A word that bypasses the buffer and is consumed in the same cycle is never stored.
  assign w_push = w_ack_live && !(w_bypass && instr_ready);
  // Redirect takes priority over a pop in the same cycle.
  assign w_pop  = w_buf_valid && instr_ready && !redirect;

  // The request is a decode of the state. It is gated by rst, so it drops
  // asynchronously when rst is asserted in the middle of a request.
  assign imem_req    = !rst && ((r_state != FETCH) || w_room);
  assign imem_addr   = (r_state == FETCH) ? r_fetch_pc : r_req_addr;

  assign instr_valid = w_buf_valid || w_bypass;
  assign instruction = w_bypass ? imem_rdata : r_instr_mem[r_rd_ptr];
  assign pc          = w_bypass ? r_req_addr : r_pc_mem[r_rd_ptr];
  assign pcNext      = pc + 32'd4;

  // Fetch sequencing: issue, wait for the ack, and track redirects (including stale reads).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_room) begin
            r_req_addr <= r_fetch_pc;
            // A redirect in the issue cycle makes this request stale right away.
            r_state    <= redirect ? DISCARD : WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (imem_ack) begin
            r_state <= FETCH;
            if (!redirect) begin
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end
          end else if (redirect) begin
            r_state <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
      // A redirect target overrides any sequential increment.
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // Prefetch buffer: a circular FIFO of {instruction, pc}. A redirect flushes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= 32'h0000_0000;
        r_pc_mem[i]    <= RESET_PC;
      end
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr_mem[r_wr_ptr] <= imem_rdata;
        r_pc_mem[r_wr_ptr]    <= r_req_addr;
        r_wr_ptr              <= r_wr_ptr + C_PTR_1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_1;
        2'b01:   r_count <= r_count - C_CNT_1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed, self-checking bench for instruction_fetch_unit
//               (RESET_PC = 0x100, DEPTH = 2). Memory responses are driven
//               cycle by cycle from the stimulus sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .pc          (pc),
    .pcNext      (pcNext),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory content: each word is its address XOR a fixed tag.
  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Moves to 1 time unit after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values; an ack arriving during reset must be ignored
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("rst_req",    {31'd0, imem_req},    32'd0);
    check_eq("rst_addr",   imem_addr,            32'h100);
    check_eq("rst_valid",  {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr",  instruction,          32'h0);
    check_eq("rst_pc",     pc,                   32'h100);
    check_eq("rst_pcnext", pcNext,               32'h104);
    tick();
    imem_ack = 1'b0; rst = 1'b0;
    #1;
    check_eq("rel_req",  {31'd0, imem_req}, 32'd1);
    check_eq("rel_addr", imem_addr,         32'h100);

    // Sequential fetch, 1-cycle memory
    tick(); imem_ack = 1'b1; imem_rdata = dat(32'h100); #1;
    check_eq("ack100_addr",  imem_addr,            32'h100);
    check_eq("ack100_valid", {31'd0, instr_valid}, BYP);
    tick(); imem_ack = 1'b0; #1;
    check_eq("v100_valid",  {31'd0, instr_valid}, 32'd1);
    check_eq("v100_instr",  instruction,          dat(32'h100));
    check_eq("v100_pc",     pc,                   32'h100);
    check_eq("v100_pcnext", pcNext,               32'h104);
    check_eq("req104_addr", imem_addr,            32'h104);
    tick(); imem_ack = 1'b1; imem_rdata = dat(32'h104); #1;
    check_eq("ack104_addr", imem_addr, 32'h104);

    // Buffer full with instr_ready low: no more requests
    tick(); imem_ack = 1'b0; #1;
    check_eq("full_req0", {31'd0, imem_req}, 32'd0);
    check_eq("full_head", pc,                32'h100);
    tick(); #1;
    check_eq("full_req1", {31'd0, imem_req}, 32'd0);
    instr_ready = 1'b1; #1;
    check_eq("full_req2", {31'd0, imem_req}, 32'd0);
    tick(); instr_ready = 1'b0; #1;
    check_eq("pop_req",  {31'd0, imem_req}, 32'd1);
    check_eq("pop_addr", imem_addr,         32'h108);
    check_eq("pop_head", pc,                32'h104);
    tick(); imem_ack = 1'b1; imem_rdata = dat(32'h108); #1;
    check_eq("ack108_addr", imem_addr, 32'h108);
    tick(); imem_ack = 1'b0; #1;
    check_eq("one_req_only", {31'd0, imem_req}, 32'd0);

    // Drain, then redirect while the request to 0x10C is outstanding
    instr_ready = 1'b1;
    tick(); #1;
    check_eq("drain_pc",   pc,        32'h108);
    check_eq("drain_addr", imem_addr, 32'h10C);
    tick(); instr_ready = 1'b0; #1;
    check_eq("empty_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("out10c_addr", imem_addr,            32'h10C);
    redirect = 1'b1; redirect_pc = 32'h0000_2002;
    tick(); redirect = 1'b0; #1;
    check_eq("disc_addr", imem_addr,         32'h10C);
    check_eq("disc_req",  {31'd0, imem_req}, 32'd1);
    tick(); imem_ack = 1'b1; imem_rdata = dat(32'h10C); #1;
    check_eq("disc_ack_valid", {31'd0, instr_valid}, 32'd0);
    tick(); imem_ack = 1'b0; #1;
    check_eq("post_disc_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("post_disc_addr",  imem_addr,            32'h2000);
    tick(); imem_ack = 1'b1; imem_rdata = dat(32'h2000); #1;
    tick(); imem_ack = 1'b0; #1;
    check_eq("v2000_instr", instruction, dat(32'h2000));
    check_eq("v2000_pc",    pc,          32'h2000);
    check_eq("req2004",     imem_addr,   32'h2004);

    // Redirect coincident with ack, and with instr_ready high
    tick();
    imem_ack = 1'b1; imem_rdata = dat(32'h2004);
    redirect = 1'b1; redirect_pc = 32'h0000_3000; instr_ready = 1'b1; #1;
    check_eq("redir_cyc_valid", {31'd0, instr_valid}, 32'd1);
    tick(); imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0; #1;
    check_eq("coinc_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("coinc_req",   {31'd0, imem_req},    32'd1);
    check_eq("coinc_addr",  imem_addr,            32'h3000);
    tick(); #1;
    check_eq("coinc_nodisc", imem_addr, 32'h3000);
    imem_ack = 1'b1; imem_rdata = dat(32'h3000);
    tick(); imem_ack = 1'b0; #1;
    check_eq("v3000_instr", instruction, dat(32'h3000));

    // Redirect to the last word of the address space (issue-cycle redirect)
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick(); redirect = 1'b0; #1;
    check_eq("stale3004_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("stale3004_addr",  imem_addr,            32'h3004);
    imem_ack = 1'b1; imem_rdata = dat(32'h3004);
    tick(); imem_ack = 1'b0; #1;
    check_eq("wrap_req_addr", imem_addr,            32'hFFFF_FFFC);
    check_eq("wrap_valid0",   {31'd0, instr_valid}, 32'd0);
    tick(); imem_ack = 1'b1; imem_rdata = dat(32'hFFFF_FFFC); #1;
    tick(); imem_ack = 1'b0; #1;
    check_eq("wrap_pc",     pc,        32'hFFFF_FFFC);
    check_eq("wrap_pcnext", pcNext,    32'h0);
    check_eq("wrap_next",   imem_addr, 32'h0);

    // Ack into an empty buffer with instr_ready high
    instr_ready = 1'b1;
    tick(); #1;
    check_eq("emp_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = dat(32'h0); #1;
    check_eq("byp_valid", {31'd0, instr_valid}, BYP);
    tick(); imem_ack = 1'b0; instr_ready = 1'b0; #1;
    check_eq("byp_after_valid", {31'd0, instr_valid}, 32'd1 - BYP);

    // Reset asserted while a request is outstanding
    tick();
    rst = 1'b1; #1;
    check_eq("mid_rst_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = dat(32'h4);
    tick(); #1;
    check_eq("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("mid_rst_addr",  imem_addr,            32'h100);
    check_eq("mid_rst_pc",    pc,                   32'h100);
    imem_ack = 1'b0; rst = 1'b0; #1;
    check_eq("rel2_req",  {31'd0, imem_req}, 32'd1);
    check_eq("rel2_addr", imem_addr,         32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
